// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage RISC-V pipeline. It runs loads and stores
// over a req/ack data bus and freezes the upstream stages while an access is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [7:0] TMO    = 8'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;

  logic        in_load, in_store, in_misalign;
  logic [3:0]  in_be;
  logic [31:0] in_bwdata;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Picks the addressed byte/half out of the bus word and extends it.
  function automatic logic [31:0] align_load(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   align_load = {{24{b[7]}}, b};
      OP_LBU:  align_load = {24'b0, b};
      OP_LH:   align_load = {{16{h[15]}}, h};
      OP_LHU:  align_load = {16'b0, h};
      default: align_load = rdata;
    endcase
  endfunction

  always_comb begin
    in_load     = is_load(mem_op_i);
    in_store    = is_store(mem_op_i);
    in_misalign = 1'b0;
    in_be       = 4'hF;
    in_bwdata   = mem_reg2_i;
    case (mem_op_i)
      OP_LH, OP_LHU: in_misalign = mem_addr_i[0];
      OP_LW, OP_SW:  in_misalign = |mem_addr_i[1:0];
      OP_SH: begin
        in_misalign = mem_addr_i[0];
        in_be       = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        in_bwdata   = {2{mem_reg2_i[15:0]}};
      end
      OP_SB: begin
        in_be     = 4'b0001 << mem_addr_i[1:0];
        in_bwdata = {4{mem_reg2_i[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    mem_wd_o     = mem_wd_i;
    mem_wreg_o   = 1'b0;
    mem_wdata_o  = mem_wdata_i;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'b0;
    dbus_be_o    = 4'b0;
    dbus_wdata_o = 32'b0;
    stallreq_o   = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!(in_load || in_store)) begin
          mem_wreg_o = mem_wreg_i;
        end else if (in_misalign) begin
          misalign_o = 1'b1;
        end else begin
          dbus_req_o   = 1'b1;
          dbus_we_o    = in_store;
          dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
          dbus_be_o    = in_be;
          dbus_wdata_o = in_bwdata;
          addr_d       = mem_addr_i;
          be_d         = in_be;
          wdata_d      = in_bwdata;
          op_d         = mem_op_i;
          wd_d         = mem_wd_i;
          wreg_d       = mem_wreg_i;
          if (dbus_ack_i) begin
            mem_wreg_o  = in_load & mem_wreg_i;
            mem_wdata_o = align_load(mem_op_i, mem_addr_i[1:0], dbus_rdata_i);
          end else begin
            stallreq_o = 1'b1;
            state_d    = S_WAIT;
            cnt_d      = 8'd1;
          end
        end
      end
      default: begin
        // Only the latched request is used here; upstream is frozen but not trusted.
        mem_wd_o     = wd_q;
        mem_wdata_o  = align_load(op_q, addr_q[1:0], dbus_rdata_i);
        dbus_req_o   = 1'b1;
        dbus_we_o    = is_store(op_q);
        dbus_addr_o  = {addr_q[31:2], 2'b00};
        dbus_be_o    = be_q;
        dbus_wdata_o = wdata_q;
        if (dbus_ack_i) begin
          mem_wreg_o = is_load(op_q) & wreg_q;
          state_d    = S_IDLE;
        end else if ((TMO != 8'd0) && (cnt_q == TMO)) begin
          dbus_req_o   = 1'b0;
          dbus_we_o    = 1'b0;
          dbus_addr_o  = 32'b0;
          dbus_be_o    = 4'b0;
          dbus_wdata_o = 32'b0;
          bus_err_o    = 1'b1;
          state_d      = S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          cnt_d      = cnt_q + 8'd1;
        end
      end
    endcase

    if (rst) begin
      mem_wd_o     = 5'b0;
      mem_wreg_o   = 1'b0;
      mem_wdata_o  = 32'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = 32'b0;
      dbus_be_o    = 4'b0;
      dbus_wdata_o = 32'b0;
      stallreq_o   = 1'b0;
      misalign_o   = 1'b0;
      bus_err_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      op_q    <= 4'b0;
      wd_q    <= 5'b0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded random bench for mem_stage: the driver predicts each cycle's
// outputs from the access rules, a monitor pops and compares them at negedge.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0, mem_reg2_i = '0, mem_wdata_i = '0, dbus_rdata_i = '0;
  logic [4:0]  mem_wd_i = '0;
  logic        mem_wreg_i = 1'b0, dbus_ack_i = 1'b0;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o, dbus_req_o, dbus_we_o, stallreq_o, misalign_o, bus_err_o;
  logic [31:0] mem_wdata_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        req, we, stall, mis, err, wreg, chk_data;
    logic [31:0] addr, bwdata, wdata;
    logic [3:0]  be;
    logic [4:0]  wd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Reference rules, written from the access table with plain arithmetic.
  function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] byte_v, half_v;
    byte_v = (rd >> (8 * int'(addr[1:0]))) & 32'hFF;
    half_v = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (op)
      1: return (byte_v >= 32'h80) ? byte_v - 32'h100 : byte_v;
      2: return (half_v >= 32'h8000) ? half_v - 32'h10000 : half_v;
      4: return byte_v;
      5: return half_v;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input int op, input logic [31:0] addr);
    if (op == 6) return 4'(1 << int'(addr[1:0]));
    if (op == 7) return addr[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_bwdata(input int op, input logic [31:0] r2);
    if (op == 6) return {4{r2[7:0]}};
    if (op == 7) return {2{r2[15:0]}};
    return r2;
  endfunction

  // Monitor: one expected record per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("req", 32'(dbus_req_o), 32'(e.req));
        chk("stall", 32'(stallreq_o), 32'(e.stall));
        chk("misalign", 32'(misalign_o), 32'(e.mis));
        chk("bus_err", 32'(bus_err_o), 32'(e.err));
        chk("wreg", 32'(mem_wreg_o), 32'(e.wreg));
        if (e.req) begin
          chk("we", 32'(dbus_we_o), 32'(e.we));
          chk("bus_addr", dbus_addr_o, e.addr);
          chk("be", 32'(dbus_be_o), 32'(e.be));
          if (e.we) chk("bus_wdata", dbus_wdata_o, e.bwdata);
        end
        if (e.chk_data) begin
          chk("wd", 32'(mem_wd_o), 32'(e.wd));
          chk("wdata", mem_wdata_o, e.wdata);
        end
      end
    end
  end

  // lat: cycle index (0 = issue cycle) on which ack is raised; -1 = never.
  task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat);
    exp_t e;
    bit   ld, st, mis;
    ld  = (op >= 1 && op <= 5);
    st  = (op >= 6 && op <= 8);
    mis = ((op == 2 || op == 5 || op == 7) && addr[0]) ||
          ((op == 3 || op == 8) && addr[1:0] != 2'b00);
    $display("txn op=%0d addr=%h reg2=%h wd=%0d wreg=%0d lat=%0d", op, addr, reg2, wd, wreg, lat);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op_i = 4'(op); mem_addr_i = addr; mem_reg2_i = reg2;
    mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = wdata; dbus_rdata_i = rdata;
    dbus_ack_i = 1'b0;
    e = blank();
    if (!ld && !st) begin
      dbus_ack_i = 1'($urandom_range(0, 1));
      e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = 1'b1;
      sb.push_back(e);
      return;
    end
    if (mis) begin
      e.mis = 1'b1;
      sb.push_back(e);
      return;
    end
    e.req = 1'b1; e.we = st; e.addr = addr & ~32'h3;
    e.be = ld ? 4'hF : ref_be(op, addr);
    e.bwdata = ref_bwdata(op, reg2);
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      dbus_ack_i = (k == lat);
      if (k == lat) begin
        e.stall = 1'b0;
        if (ld) begin
          e.wreg = wreg; e.wd = wd; e.wdata = ref_load(op, addr, rdata); e.chk_data = 1'b1;
        end
        sb.push_back(e);
        break;
      end
      if (k > 0 && TMO != 0 && k == TMO) begin
        e.req = 1'b0; e.err = 1'b1; e.stall = 1'b0;
        sb.push_back(e);
        break;
      end
      e.stall = 1'b1;
      sb.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    int   op, lsel, lat;
    logic [31:0] a;
    // Reset: outputs held at zero even with live inputs.
    mem_op_i = 4'd0; mem_wd_i = 5'd5; mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234; dbus_ack_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      e = blank(); e.chk_data = 1'b1;
      sb.push_back(e);
    end

    run_txn(0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, 0);
    run_txn(1, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 32'h80FF_FF00, 0);
    run_txn(5, 32'h202, 32'h0, 5'd9, 1'b1, 32'h0, 32'hBEEF_0000, 3);
    run_txn(6, 32'h11, 32'hAB, 5'd2, 1'b1, 32'h0, 32'h0, 0);
    run_txn(7, 32'h12, 32'hCAFE, 5'd2, 1'b1, 32'h0, 32'h0, 0);
    run_txn(3, 32'h6, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0, 0);
    run_txn(3, 32'h40, 32'h0, 5'd4, 1'b1, 32'h0, 32'h1111_2222, -1);
    run_txn(2, 32'h3E, 32'h0, 5'd8, 1'b1, 32'h0, 32'h8001_7FFF, TMO);

    for (int i = 0; i < 300; i++) begin
      op   = int'($urandom_range(0, 10));
      lsel = int'($urandom_range(0, 6));
      lat  = (lsel == 6) ? -1 : lsel;
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom, lat);
    end

    // Reset while waiting: access abandoned, a late ack writes nothing back.
    $display("txn reset-mid-wait");
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = 4'd3; mem_addr_i = 32'h80; mem_wd_i = 5'd6; mem_wreg_i = 1'b1;
    dbus_ack_i = 1'b0; dbus_rdata_i = 32'h5555_AAAA;
    e = blank(); e.req = 1'b1; e.addr = 32'h80; e.be = 4'hF; e.stall = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    sb.push_back(e);
    @(posedge clk); #1;
    rst = 1'b1;
    e = blank(); e.chk_data = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = 4'd0; mem_wd_i = 5'd7; mem_wreg_i = 1'b0; mem_wdata_i = 32'h77;
    dbus_ack_i = 1'b1;
    e = blank(); e.wd = 5'd7; e.wdata = 32'h77; e.chk_data = 1'b1;
    sb.push_back(e);

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
